// File: rtl/watch_pkg.sv
// Shared constants, field widths, set_sel encodings and FSM state type
// for the watch timekeeping slice.
package watch_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'b00,
    SEL_MIN  = 2'b01,
    SEL_HR   = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a delay flop
// that turns each rising edge into a single one-clk strobe.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise_pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/watch_timekeeper.sv
// Hours:minutes:seconds keeper driven by the divided watch clock, with a
// SET mode that lets the user bump one field at a time without carries.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int HOUR_MAX      = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             set_en,
  input  logic [1:0]       set_sel,
  input  logic             inc_btn,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic             sec_pulse,
  output logic             day_pulse
);

  localparam int              PRE_W    = 10;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(HOUR_MAX);

  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] last);
    return (v == last) ? 5'd0 : v + 5'd1;
  endfunction

  logic tick_rise;
  logic inc_rise;
  logic set_p0;
  logic set_p1;

  sync_edge_detect u_tick_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (tick_in),
    .rise_pulse (tick_rise)
  );

  sync_edge_detect u_inc_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (inc_btn),
    .rise_pulse (inc_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_p0 <= 1'b0;
      set_p1 <= 1'b0;
    end else begin
      set_p0 <= set_en;
      set_p1 <= set_p0;
    end
  end

  state_e state;
  state_e state_nxt;
  logic   run_go;
  logic   set_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = set_p1 ? ST_SET : ST_RUN;
  end

  // Strobes arriving in a transition cycle belong to neither mode and are dropped.
  always_comb begin
    run_go = (state == ST_RUN) && (state_nxt == ST_RUN);
    set_go = (state == ST_SET) && (state_nxt == ST_SET);
  end

  logic [PRE_W-1:0] presc;
  logic             tick_go;
  logic             sec_due;

  assign tick_go = run_go & tick_rise;
  assign sec_due = tick_go && (presc == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        presc <= '0;
    else if (!run_go)  presc <= '0;
    else if (tick_go)  presc <= sec_due ? '0 : presc + 1'b1;
  end

  // Full sec->min->hr ripple resolves on a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec       <= '0;
      min       <= '0;
      hr        <= '0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      if (sec_due) begin
        sec_pulse <= 1'b1;
        sec       <= inc_wrap6(sec, SEC_MAX);
        if (sec == SEC_MAX) begin
          min <= inc_wrap6(min, MIN_MAX);
          if (min == MIN_MAX) begin
            hr <= inc_wrap5(hr, HR_LAST);
            if (hr == HR_LAST) day_pulse <= 1'b1;
          end
        end
      end else if (set_go && inc_rise) begin
        case (sel_e'(set_sel))
          SEL_SEC:  sec <= inc_wrap6(sec, SEC_MAX);
          SEL_MIN:  min <= inc_wrap6(min, MIN_MAX);
          SEL_HR:   hr  <= inc_wrap5(hr, HR_LAST);
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper: one instance at 1 tick/s, one at 4 ticks/s.
module tb_watch_timekeeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0, set_en = 1'b0, inc = 1'b0;
  logic [1:0] sel = 2'b11;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       sp, dp;

  logic       tick4 = 1'b0, set4 = 1'b0, inc4 = 1'b0;
  logic [1:0] sel4 = 2'b11;
  logic [5:0] sec4, min4;
  logic [4:0] hr4;
  logic       sp4, dp4;

  int n_cmp = 0;
  int n_err = 0;
  int sp_cnt = 0;
  int dp_cnt = 0;

  watch_timekeeper #(.TICKS_PER_SEC(1), .HOUR_MAX(23)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick), .set_en(set_en), .set_sel(sel),
    .inc_btn(inc), .sec(sec), .min(min), .hr(hr), .sec_pulse(sp), .day_pulse(dp)
  );

  watch_timekeeper #(.TICKS_PER_SEC(4), .HOUR_MAX(23)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick4), .set_en(set4), .set_sel(sel4),
    .inc_btn(inc4), .sec(sec4), .min(min4), .hr(hr4), .sec_pulse(sp4), .day_pulse(dp4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sp === 1'b1) sp_cnt += 1;
    if (dp === 1'b1) dp_cnt += 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got %0d compared, want completion", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) inc = 1'b1;
    repeat (4) @(negedge clk);
    inc = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_field(input logic [1:0] s, input int n);
    sel = s;
    for (int i = 0; i < n; i++) press();
  endtask

  task automatic enter_set();
    @(negedge clk) set_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic leave_set();
    @(negedge clk) set_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_pulse();
    @(negedge clk) tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic tick4_pulse();
    @(negedge clk) tick4 = 1'b1;
    repeat (4) @(negedge clk);
    tick4 = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tick   = ($urandom % 2) == 1;
      set_en = ($urandom % 2) == 1;
      inc    = ($urandom % 2) == 1;
      sel    = 2'($urandom_range(0, 3));
      n_cmp++;
      if ({hr, min, sec} !== 17'd0) begin
        n_err++;
        $display("FAIL reset_time cyc%0d: got %0d:%0d:%0d want 0:0:0", c, hr, min, sec);
      end
      n_cmp++;
      if ({sp, dp} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_pulses cyc%0d: got sp=%b dp=%b want 0 0", c, sp, dp);
      end
    end
    tick = 1'b0; set_en = 1'b0; inc = 1'b0; sel = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({hr, min, sec, sp, dp} !== 19'd0) begin
      n_err++;
      $display("FAIL post_reset: got %0d:%0d:%0d sp=%b dp=%b want 0:0:0 0 0", hr, min, sec, sp, dp);
    end
  endtask

  task automatic test_run();
    int s0;
    s0 = sp_cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sec !== 6'(i)) begin
        n_err++;
        $display("FAIL run_early tick%0d: got sec=%0d want %0d", i, sec, i);
      end
      @(negedge clk);
      n_cmp++;
      if (sec !== 6'((i + 1) % 60) || sp !== 1'b1) begin
        n_err++;
        $display("FAIL run_edge3 tick%0d: got sec=%0d sp=%b want %0d 1", i, sec, sp, (i + 1) % 60);
      end
      tick = 1'b0;
      repeat (7) @(negedge clk);
    end
    n_cmp++;
    if ({hr, min, sec} !== {5'd0, 6'd1, 6'd0}) begin
      n_err++;
      $display("FAIL run_final: got %0d:%0d:%0d want 0:1:0", hr, min, sec);
    end
    n_cmp++;
    if (sp_cnt - s0 !== 60) begin
      n_err++;
      $display("FAIL run_pulses: got %0d want 60", sp_cnt - s0);
    end
  endtask

  task automatic test_day_rollover();
    int d0;
    do_reset();
    enter_set();
    set_field(2'b00, 58);
    set_field(2'b01, 59);
    set_field(2'b10, 23);
    sel = 2'b11;
    leave_set();
    n_cmp++;
    if ({hr, min, sec} !== {5'd23, 6'd59, 6'd58}) begin
      n_err++;
      $display("FAIL preload: got %0d:%0d:%0d want 23:59:58", hr, min, sec);
    end
    @(negedge clk) tick = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({hr, min, sec, sp, dp} !== {5'd23, 6'd59, 6'd59, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL to_2359: got %0d:%0d:%0d sp=%b dp=%b want 23:59:59 1 0", hr, min, sec, sp, dp);
    end
    tick = 1'b0;
    repeat (7) @(negedge clk);
    d0 = dp_cnt;
    @(negedge clk) tick = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({hr, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
      n_err++;
      $display("FAIL before_wrap: got %0d:%0d:%0d want 23:59:59", hr, min, sec);
    end
    @(negedge clk);
    n_cmp++;
    if ({hr, min, sec, sp, dp} !== {17'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL day_wrap: got %0d:%0d:%0d sp=%b dp=%b want 0:0:0 1 1", hr, min, sec, sp, dp);
    end
    @(negedge clk);
    n_cmp++;
    if (dp !== 1'b0) begin
      n_err++;
      $display("FAIL day_pulse_width: got dp=%b want 0", dp);
    end
    tick = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (dp_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL day_pulse_count: got %0d want 1", dp_cnt - d0);
    end
  endtask

  task automatic test_set_wrap();
    int s0, d0;
    enter_set();
    set_field(2'b01, 59);
    n_cmp++;
    if ({hr, min, sec} !== {5'd0, 6'd59, 6'd0}) begin
      n_err++;
      $display("FAIL set_min59: got %0d:%0d:%0d want 0:59:0", hr, min, sec);
    end
    s0 = sp_cnt;
    d0 = dp_cnt;
    press();
    n_cmp++;
    if ({hr, min, sec} !== 17'd0) begin
      n_err++;
      $display("FAIL set_min_wrap: got %0d:%0d:%0d want 0:0:0", hr, min, sec);
    end
    tick_pulse();
    n_cmp++;
    if ({hr, min, sec} !== 17'd0) begin
      n_err++;
      $display("FAIL set_tick_ignored: got %0d:%0d:%0d want 0:0:0", hr, min, sec);
    end
    sel = 2'b11;
    press();
    n_cmp++;
    if ({hr, min, sec} !== 17'd0) begin
      n_err++;
      $display("FAIL set_sel_none: got %0d:%0d:%0d want 0:0:0", hr, min, sec);
    end
    set_field(2'b00, 1);
    n_cmp++;
    if ({hr, min, sec} !== {5'd0, 6'd0, 6'd1}) begin
      n_err++;
      $display("FAIL set_sel_change: got %0d:%0d:%0d want 0:0:1", hr, min, sec);
    end
    n_cmp++;
    if ((sp_cnt - s0) !== 0 || (dp_cnt - d0) !== 0) begin
      n_err++;
      $display("FAIL set_no_pulses: got sp=%0d dp=%0d want 0 0", sp_cnt - s0, dp_cnt - d0);
    end
    sel = 2'b11;
    leave_set();
  endtask

  task automatic test_prescaler();
    do_reset();
    repeat (3) tick4_pulse();
    n_cmp++;
    if (sec4 !== 6'd0) begin
      n_err++;
      $display("FAIL presc_3ticks: got sec=%0d want 0", sec4);
    end
    @(negedge clk) set4 = 1'b1;
    repeat (5) @(negedge clk);
    set4 = 1'b0;
    repeat (5) @(negedge clk);
    repeat (3) tick4_pulse();
    n_cmp++;
    if ({hr4, min4, sec4} !== 17'd0) begin
      n_err++;
      $display("FAIL presc_cleared: got %0d:%0d:%0d want 0:0:0", hr4, min4, sec4);
    end
    @(negedge clk) tick4 = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sec4 !== 6'd0) begin
      n_err++;
      $display("FAIL presc_4th_early: got sec=%0d want 0", sec4);
    end
    @(negedge clk);
    n_cmp++;
    if (sec4 !== 6'd1 || sp4 !== 1'b1) begin
      n_err++;
      $display("FAIL presc_4th: got sec=%0d sp=%b want 1 1", sec4, sp4);
    end
    tick4 = 1'b0;
    repeat (5) @(negedge clk);
    repeat (4) tick4_pulse();
    n_cmp++;
    if (sec4 !== 6'd2 || dp4 !== 1'b0) begin
      n_err++;
      $display("FAIL presc_next_sec: got sec=%0d dp=%b want 2 0", sec4, dp4);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    enter_set();
    set_field(2'b00, 56);
    set_field(2'b01, 34);
    set_field(2'b10, 12);
    sel = 2'b11;
    leave_set();
    n_cmp++;
    if ({hr, min, sec} !== {5'd12, 6'd34, 6'd56}) begin
      n_err++;
      $display("FAIL mid_preload: got %0d:%0d:%0d want 12:34:56", hr, min, sec);
    end
    s0 = sp_cnt;
    @(negedge clk) tick = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({hr, min, sec} !== {5'd12, 6'd34, 6'd56}) begin
      n_err++;
      $display("FAIL mid_inflight: got %0d:%0d:%0d want 12:34:56", hr, min, sec);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hr, min, sec, sp, dp} !== 19'd0) begin
      n_err++;
      $display("FAIL mid_async_clear: got %0d:%0d:%0d sp=%b dp=%b want 0:0:0 0 0", hr, min, sec, sp, dp);
    end
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({hr, min, sec} !== 17'd0 || sp_cnt != s0) begin
      n_err++;
      $display("FAIL mid_after_release: got %0d:%0d:%0d pulses=%0d want 0:0:0 0", hr, min, sec, sp_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_day_rollover();
    test_set_wrap();
    test_prescaler();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
